// File: rtl/sd_spi_arbiter.sv
// Round-robin arbiter sharing one SD SPI host between two requesters.
// A grant lasts the whole transaction; a drain and gap phase separates consecutive grants.
module sd_spi_arbiter #(
  parameter int GAP_CYCLES = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  output logic [1:0]          gnt,
  input  logic [1:0]          m_r_block,
  input  logic [1:0]          m_r_byte,
  input  logic [1:0]          m_r_multi_block,
  input  logic [1:0]          m_spi_rst,
  input  logic [1:0]          m_w_block,
  input  logic [1:0]          m_w_byte,
  input  logic [2*ADDR_W-1:0] m_block_addr,
  input  logic [15:0]         m_data_in,
  output logic [1:0]          m_busy,
  output logic [7:0]          m_data_out,
  output logic [1:0]          m_err,
  output logic [1:0]          m_crc_err,
  input  logic                spi_busy,
  input  logic [7:0]          spi_data_out,
  input  logic                spi_err,
  input  logic                spi_crc_err,
  output logic                spi_r_block,
  output logic                spi_r_byte,
  output logic                spi_r_multi_block,
  output logic                spi_rst,
  output logic                spi_w_block,
  output logic                spi_w_byte,
  output logic [ADDR_W-1:0]   spi_block_addr,
  output logic [7:0]          spi_data_in
);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN, GAP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                cur_q, cur_d;
  logic                last_q, last_d;
  logic [7:0]          gap_q, gap_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic                granted;
  logic                pick;
  logic [ADDR_W-1:0]   sel_addr;
  logic [7:0]          sel_din;

  assign granted  = (state_q == GRANT);
  assign sel_addr = cur_q ? m_block_addr[ADDR_W +: ADDR_W] : m_block_addr[0 +: ADDR_W];
  assign sel_din  = cur_q ? m_data_in[8 +: 8] : m_data_in[0 +: 8];
  // On contention the port that was not served last wins; otherwise the lone requester wins.
  assign pick     = (req == 2'b11) ? ~last_q : req[1];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cur_d   = cur_q;
    last_d  = last_q;
    gap_d   = gap_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          cur_d   = pick;
          gnt_d   = pick ? 2'b10 : 2'b01;
          state_d = GRANT;
        end
      end
      GRANT: begin
        addr_d = sel_addr;
        if (!req[cur_q]) begin
          gnt_d   = 2'b00;
          last_d  = cur_q;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Wait for the host to finish whatever the released port started.
        if (!spi_busy) begin
          gap_d   = 8'(GAP_CYCLES - 1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      cur_q   <= 1'b0;
      last_q  <= 1'b1;
      gap_q   <= 8'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      addr_q  <= addr_d;
    end
  end

  assign gnt        = gnt_q;
  assign m_data_out = spi_data_out;

  always_comb begin
    spi_r_block       = 1'b0;
    spi_r_byte        = 1'b0;
    spi_r_multi_block = 1'b0;
    spi_rst           = 1'b0;
    spi_w_block       = 1'b0;
    spi_w_byte        = 1'b0;
    spi_block_addr    = addr_q;
    spi_data_in       = 8'hFF;
    m_busy            = 2'b11;
    m_err             = 2'b00;
    m_crc_err         = 2'b00;
    if (granted) begin
      spi_r_block        = m_r_block[cur_q];
      spi_r_byte         = m_r_byte[cur_q];
      spi_r_multi_block  = m_r_multi_block[cur_q];
      spi_rst            = m_spi_rst[cur_q];
      spi_w_block        = m_w_block[cur_q];
      spi_w_byte         = m_w_byte[cur_q];
      spi_block_addr     = sel_addr;
      spi_data_in        = sel_din;
      m_busy[cur_q]      = spi_busy;
      m_err[cur_q]       = spi_err;
      m_crc_err[cur_q]   = spi_crc_err;
    end
  end

endmodule
